// File: rtl/ram_banked_wb_pkg.sv
// Shared types and macro geometry for the banked Wishbone RAM.
package ram_banked_wb_pkg;

   localparam int ROWS   = 512;
   localparam int LANE_W = 8;
   localparam int ROW_W  = $clog2(ROWS);

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_ACK
   } state_e;

   // Bank index width; never zero, even for a single-bank configuration.
   function automatic int bank_width(input int aw);
      return (aw > ROW_W) ? (aw - ROW_W) : 1;
   endfunction

endpackage

// File: rtl/ram512x8.sv
// 512 x 8 single-port synchronous SRAM macro model: registered read, write-no-read.
module ram512x8
   import ram_banked_wb_pkg::*;
(
`ifdef USE_POWER_PINS
   inout  wire               vccd1,
   inout  wire               vssd1,
`endif
   input  logic              clk_i,
   input  logic              cen_i,
   input  logic              we_i,
   input  logic [ROW_W-1:0]  addr_i,
   input  logic [LANE_W-1:0] din_i,
   output logic [LANE_W-1:0] dout_o
);

   logic [LANE_W-1:0] mem_q [ROWS];
   logic [LANE_W-1:0] dout_q;

   // NOTE: the array and read register have no reset; a macro cannot be reset,
   // so zeroing is done by the owner sweeping every row.
   always_ff @(posedge clk_i) begin
      if (cen_i) begin
         if (we_i) begin
            mem_q[addr_i] <= din_i;
         end else begin
            dout_q <= mem_q[addr_i];
         end
      end
   end

   assign dout_o = dout_q;

endmodule

// File: rtl/ram_banked_wb.sv
// Wishbone classic slave over a grid of ram512x8 macros, one transfer per two cycles.
module ram_banked_wb
   import ram_banked_wb_pkg::*;
#(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned DEPTH          = 1024,
   parameter bit          CLEAR_ON_RESET = 1'b1,
   localparam int         NL             = WIDTH / LANE_W,
   localparam int         AW             = $clog2(DEPTH)
) (
`ifdef USE_POWER_PINS
   inout  wire              vccd1,
   inout  wire              vssd1,
`endif
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wb_cyc_i,
   input  logic             wb_stb_i,
   input  logic             wb_we_i,
   input  logic [NL-1:0]    wb_sel_i,
   input  logic [AW-1:0]    wb_adr_i,
   input  logic [WIDTH-1:0] wb_dat_i,
   output logic [WIDTH-1:0] wb_dat_o,
   output logic             wb_ack_o,
   output logic             busy_o
);

   localparam int NB = DEPTH / ROWS;
   localparam int BW = bank_width(AW);

   if ((WIDTH % LANE_W) != 0 || WIDTH == 0) begin : g_bad_width
      $error("ram_banked_wb: WIDTH must be a non-zero multiple of 8");
   end
   if ((DEPTH % ROWS) != 0 || DEPTH == 0) begin : g_bad_depth
      $error("ram_banked_wb: DEPTH must be a non-zero multiple of 512");
   end

   state_e             state_q, state_d;
   logic [ROW_W-1:0]   cnt_q, cnt_d;
   logic [BW-1:0]      bank_q, bank_d;
   logic [BW-1:0]      bank_sel;

   logic [NB-1:0]      bank_en;
   logic [NL-1:0]      lane_we;
   logic [ROW_W-1:0]   mem_addr;
   logic [WIDTH-1:0]   mem_din;
   logic [NB-1:0][WIDTH-1:0] rd_data;

   if (AW > ROW_W) begin : g_multi_bank
      assign bank_sel = wb_adr_i[AW-1:ROW_W];
   end else begin : g_single_bank
      assign bank_sel = '0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         cnt_q   <= '0;
         bank_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bank_q  <= bank_d;
      end
   end

   // NOTE: every signal written here is defaulted first so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bank_d   = bank_q;
      bank_en  = '0;
      lane_we  = '0;
      mem_addr = wb_adr_i[ROW_W-1:0];
      mem_din  = wb_dat_i;

      unique case (state_q)
         ST_CLEAR: begin
            bank_en  = '1;
            lane_we  = '1;
            mem_addr = cnt_q;
            mem_din  = '0;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == ROW_W'(ROWS - 1)) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               for (int b = 0; b < NB; b++) begin
                  bank_en[b] = (bank_sel == BW'(b));
               end
               lane_we = {NL{wb_we_i}} & wb_sel_i;
               bank_d  = bank_sel;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   for (genvar b = 0; b < NB; b++) begin : g_bank
      for (genvar l = 0; l < NL; l++) begin : g_lane
         ram512x8 u_ram (
`ifdef USE_POWER_PINS
            .vccd1  (vccd1),
            .vssd1  (vssd1),
`endif
            .clk_i  (clk_i),
            .cen_i  (bank_en[b]),
            .we_i   (lane_we[l]),
            .addr_i (mem_addr),
            .din_i  (mem_din[l*LANE_W +: LANE_W]),
            .dout_o (rd_data[b][l*LANE_W +: LANE_W])
         );
      end
   end

   assign busy_o   = (state_q == ST_CLEAR);
   // A master that drops cyc mid-transfer sees no ack; the access itself stands.
   assign wb_ack_o = (state_q == ST_ACK) && wb_cyc_i;

   always_comb begin
      wb_dat_o = '0;
      if (wb_ack_o) begin
         for (int b = 0; b < NB; b++) begin
            if (bank_q == BW'(b)) begin
               wb_dat_o = rd_data[b];
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_banked_wb.sv
// Directed self-checking bench for ram_banked_wb (32x1024 and 64x512 instances).
module tb_ram_banked_wb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [9:0]  adr;
   logic [31:0] dat_w, dat_r;
   logic        ack, busy;

   logic        cyc64, stb64, we64;
   logic [7:0]  sel64;
   logic [8:0]  adr64;
   logic [63:0] dat_w64, dat_r64;
   logic        ack64, busy64;

   int n_checks = 0;
   int n_fail   = 0;

   ram_banked_wb #(.WIDTH(32), .DEPTH(1024), .CLEAR_ON_RESET(1'b1)) u_dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .wb_cyc_i (cyc),
      .wb_stb_i (stb),
      .wb_we_i  (we),
      .wb_sel_i (sel),
      .wb_adr_i (adr),
      .wb_dat_i (dat_w),
      .wb_dat_o (dat_r),
      .wb_ack_o (ack),
      .busy_o   (busy)
   );

   ram_banked_wb #(.WIDTH(64), .DEPTH(512), .CLEAR_ON_RESET(1'b1)) u_dut64 (
      .clk_i    (clk),
      .rst_i    (rst),
      .wb_cyc_i (cyc64),
      .wb_stb_i (stb64),
      .wb_we_i  (we64),
      .wb_sel_i (sel64),
      .wb_adr_i (adr64),
      .wb_dat_i (dat_w64),
      .wb_dat_o (dat_r64),
      .wb_ack_o (ack64),
      .busy_o   (busy64)
   );

   // One classic transfer: ack_pre is sampled before the accepting edge, ack_post after it.
   task automatic wb32(input logic w, input logic [3:0] s, input logic [9:0] a,
                       input logic [31:0] d, output logic ack_pre, output logic ack_post,
                       output logic [31:0] rd);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat_w = d;
      #1 ack_pre = ack;
      @(posedge clk); #1;
      ack_post = ack;
      rd       = dat_r;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wb64(input logic w, input logic [7:0] s, input logic [8:0] a,
                       input logic [63:0] d, output logic ack_post, output logic [63:0] rd);
      @(posedge clk); #1;
      cyc64 = 1'b1; stb64 = 1'b1; we64 = w; sel64 = s; adr64 = a; dat_w64 = d;
      @(posedge clk); #1;
      ack_post = ack64;
      rd       = dat_r64;
      cyc64 = 1'b0; stb64 = 1'b0; we64 = 1'b0;
   endtask

   task automatic test_reset();
      int cnt;
      logic ap, aq;
      logic [31:0] rd;
      #1;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL reset_busy: got %b expected 1", busy);
      end
      n_checks++;
      if (ack !== 1'b0) begin
         n_fail++; $display("FAIL reset_ack: got %b expected 0", ack);
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 2000) begin
         cnt++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (cnt != 512) begin
         n_fail++; $display("FAIL clear_length: got %0d cycles expected 512", cnt);
      end
      wb32(1'b0, 4'hF, 10'h3FF, 32'h0, ap, aq, rd);
      n_checks++;
      if (aq !== 1'b1) begin
         n_fail++; $display("FAIL clear_read_ack: got %b expected 1", aq);
      end
      n_checks++;
      if (rd !== 32'h0000_0000) begin
         n_fail++; $display("FAIL clear_read_3ff: got %h expected 00000000", rd);
      end
   endtask

   task automatic test_byte_lanes();
      logic ap, aq;
      logic [31:0] rd;
      wb32(1'b1, 4'hF, 10'h005, 32'hDEAD_BEEF, ap, aq, rd);
      n_checks++;
      if (ap !== 1'b0 || aq !== 1'b1) begin
         n_fail++; $display("FAIL lane_wr1_ack: got pre=%b post=%b expected 0 1", ap, aq);
      end
      wb32(1'b1, 4'h1, 10'h005, 32'h0000_00AA, ap, aq, rd);
      n_checks++;
      if (ap !== 1'b0 || aq !== 1'b1) begin
         n_fail++; $display("FAIL lane_wr2_ack: got pre=%b post=%b expected 0 1", ap, aq);
      end
      wb32(1'b0, 4'h0, 10'h005, 32'h0, ap, aq, rd);
      n_checks++;
      if (ap !== 1'b0 || aq !== 1'b1) begin
         n_fail++; $display("FAIL lane_rd_ack: got pre=%b post=%b expected 0 1", ap, aq);
      end
      n_checks++;
      if (rd !== 32'hDEAD_BEAA) begin
         n_fail++; $display("FAIL lane_merge: got %h expected deadbeaa", rd);
      end
   endtask

   task automatic test_bank_isolation();
      logic ap, aq;
      logic [31:0] rd;
      wb32(1'b1, 4'hF, 10'h005, 32'h1111_1111, ap, aq, rd);
      wb32(1'b1, 4'hF, 10'h205, 32'h2222_2222, ap, aq, rd);
      wb32(1'b0, 4'hF, 10'h005, 32'h0, ap, aq, rd);
      n_checks++;
      if (aq !== 1'b1 || rd !== 32'h1111_1111) begin
         n_fail++; $display("FAIL bank0_read: got ack=%b data=%h expected 1 11111111", aq, rd);
      end
      wb32(1'b0, 4'hF, 10'h205, 32'h0, ap, aq, rd);
      n_checks++;
      if (aq !== 1'b1 || rd !== 32'h2222_2222) begin
         n_fail++; $display("FAIL bank1_read: got ack=%b data=%h expected 1 22222222", aq, rd);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] pat;
      int acks;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 10'h005;
      acks = 0;
      pat  = '0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         pat[k] = ack;
         if (ack === 1'b1) begin
            acks++;
            n_checks++;
            if (dat_r !== 32'h1111_1111) begin
               n_fail++; $display("FAIL b2b_data[%0d]: got %h expected 11111111", k, dat_r);
            end
         end else begin
            n_checks++;
            if (dat_r !== 32'h0) begin
               n_fail++; $display("FAIL b2b_idle_zero[%0d]: got %h expected 00000000", k, dat_r);
            end
         end
      end
      cyc = 1'b0; stb = 1'b0;
      n_checks++;
      if (acks != 5) begin
         n_fail++; $display("FAIL b2b_count: got %0d acks expected 5", acks);
      end
      n_checks++;
      if (pat !== 10'h155) begin
         n_fail++; $display("FAIL b2b_pattern: got %b expected 0101010101", pat);
      end
   endtask

   task automatic test_ack_gating();
      logic ap, aq;
      logic [31:0] rd;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 10'h010; dat_w = 32'h1234_5678;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      #1;
      n_checks++;
      if (ack !== 1'b0) begin
         n_fail++; $display("FAIL gated_ack: got %b expected 0", ack);
      end
      wb32(1'b0, 4'hF, 10'h010, 32'h0, ap, aq, rd);
      n_checks++;
      if (aq !== 1'b1 || rd !== 32'h1234_5678) begin
         n_fail++; $display("FAIL gated_write_kept: got ack=%b data=%h expected 1 12345678", aq, rd);
      end
   endtask

   task automatic test_reset_abort();
      int cnt, acks;
      logic ap, aq;
      logic [31:0] rd;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 10'h005;
      @(posedge clk); #1;
      // Read accepted; reset lands in its ack cycle while a write request is held.
      rst = 1'b1;
      we = 1'b1; dat_w = 32'hFFFF_FFFF;
      #1;
      n_checks++;
      if (ack !== 1'b0) begin
         n_fail++; $display("FAIL abort_ack: got %b expected 0", ack);
      end
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL abort_busy_async: got %b expected 1", busy);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      cnt  = 0;
      acks = 0;
      while (busy === 1'b1 && cnt < 2000) begin
         cnt++;
         if (ack === 1'b1) acks++;
         @(posedge clk); #1;
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      n_checks++;
      if (cnt != 512) begin
         n_fail++; $display("FAIL abort_clear_length: got %0d cycles expected 512", cnt);
      end
      n_checks++;
      if (acks != 0) begin
         n_fail++; $display("FAIL clear_ignores_req: got %0d acks expected 0", acks);
      end
      wb32(1'b0, 4'hF, 10'h005, 32'h0, ap, aq, rd);
      n_checks++;
      if (aq !== 1'b1 || rd !== 32'h0) begin
         n_fail++; $display("FAIL abort_reclear_005: got ack=%b data=%h expected 1 00000000", aq, rd);
      end
      wb32(1'b0, 4'hF, 10'h205, 32'h0, ap, aq, rd);
      n_checks++;
      if (aq !== 1'b1 || rd !== 32'h0) begin
         n_fail++; $display("FAIL abort_reclear_205: got ack=%b data=%h expected 1 00000000", aq, rd);
      end
   endtask

   task automatic test_wide();
      logic aq;
      logic [63:0] rd;
      n_checks++;
      if (busy64 !== 1'b0) begin
         n_fail++; $display("FAIL wide_idle: got busy=%b expected 0", busy64);
      end
      wb64(1'b1, 8'hF0, 9'h003, 64'h0123_4567_89AB_CDEF, aq, rd);
      wb64(1'b0, 8'h00, 9'h003, 64'h0, aq, rd);
      n_checks++;
      if (aq !== 1'b1 || rd !== 64'h0123_4567_0000_0000) begin
         n_fail++; $display("FAIL wide_lanes: got ack=%b data=%h expected 1 0123456700000000", aq, rd);
      end
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat_w = '0;
      cyc64 = 1'b0; stb64 = 1'b0; we64 = 1'b0; sel64 = '0; adr64 = '0; dat_w64 = '0;
      test_reset();
      test_byte_lanes();
      test_bank_isolation();
      test_back_to_back();
      test_ack_gating();
      test_reset_abort();
      test_wide();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_banked_wb.md
RAM_BANKED_WB -- requirements
Module: ram_banked_wb

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be a multiple of 8 (NL = WIDTH/8 byte lanes).
REQ-002 Parameter DEPTH, default 1024, words; SHALL be a multiple of 512 (NB = DEPTH/512 banks, AW = clog2(DEPTH)).
REQ-003 Parameter CLEAR_ON_RESET, default 1, zero-fill all memory after reset when 1.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous and active-high.
REQ-006 wb_cyc_i  in  1  bus cycle active.
REQ-007 wb_stb_i  in  1  request strobe.
REQ-008 wb_we_i  in  1  1 = write, 0 = read.
REQ-009 wb_sel_i  in  NL  byte-lane write enables.
REQ-010 wb_adr_i  in  AW  word address.
REQ-011 wb_dat_i  in  WIDTH  write data.
REQ-012 wb_dat_o  out  WIDTH  read data, valid while wb_ack_o=1.
REQ-013 wb_ack_o  out  1  single-cycle acknowledge.
REQ-014 busy_o  out  1  high while clearing; requests not accepted.

Function
REQ-015 Storage SHALL be NB x NL ram512x8 macros; bank = wb_adr_i[AW-1:9], row = wb_adr_i[8:0], lane i = bits 8i+7:8i.
REQ-016 FSM states: CLEAR, IDLE, ACK; reset enters CLEAR if CLEAR_ON_RESET=1, else IDLE.
REQ-017 CLEAR: 9-bit counter from 0 writes zero to that row of every macro each cycle; after row 511 written, next state IDLE; duration 512 cycles.
REQ-018 IDLE: request accepted when wb_cyc_i & wb_stb_i; only the selected bank's macros get cen asserted that cycle; write enable per lane = wb_we_i & wb_sel_i[i].
REQ-019 Accepted request SHALL move to ACK; wb_ack_o=1 exactly in the cycle after acceptance (latency 1), for reads and writes.
REQ-020 ACK: no new request accepted; always returns to IDLE next cycle; throughput one transfer per 2 cycles.
REQ-021 Read data SHALL be the macro outputs of the bank registered at acceptance; wb_dat_o muxed by that registered bank index, zero when wb_ack_o=0.
REQ-022 Lanes with wb_sel_i[i]=0 SHALL keep prior contents on write; wb_sel_i ignored on reads.
REQ-023 Read of an address in the cycle after a write to it SHALL return the written data (no hazard, since ACK separates them).
REQ-024 wb_cyc_i deasserted during ACK: wb_ack_o still pulses internally but output is gated to wb_ack_o = ack_q & wb_cyc_i; a write already performed is not undone.
REQ-025 Requests during CLEAR SHALL be ignored (no ack, no macro access); the master waits.
REQ-026 busy_o = 1 exactly in CLEAR state.

Reset
REQ-027 Asserting rst_i at any time SHALL force state CLEAR/IDLE per REQ-016, clear counter to 0, wb_ack_o=0, busy_o=CLEAR_ON_RESET, bank register 0; an in-flight access is abandoned without ack.
REQ-028 Memory contents are not reset when CLEAR_ON_RESET=0.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (CLEAR, IDLE, ACK) and the macro constants ROWS=512, LANE_W=8.
REQ-030 Sub-module ram512x8 is instantiated NB*NL times via nested generate; no other sub-module; power pins passed through under USE_POWER_PINS.
REQ-031 Elaboration SHALL fail if WIDTH%8 != 0 or DEPTH%512 != 0.

Verification
REQ-032 Reset with CLEAR_ON_RESET=1 -> busy_o high exactly 512 cycles, then read adr 0x3FF returns 0x00000000.
REQ-033 Write 0xDEADBEEF sel=0xF adr 0x005, then write 0x000000AA sel=0x1 adr 0x005, read adr 0x005 -> 0xDEADBEAA, ack 1 cycle after each stb.
REQ-034 Write 0x11111111 to adr 0x005 and 0x22222222 to adr 0x205 -> reads return each value (bank isolation).
REQ-035 Continuous stb held high for 10 cycles -> exactly 5 acks, alternating cycles.
REQ-036 rst_i pulse in the cycle after accepting a read -> no ack; busy_o rises asynchronously; clear restarts from row 0.
REQ-037 WIDTH=64, DEPTH=512: write 0x0123456789ABCDEF sel=0xF0 -> read returns 0x0123456700000000 after clear.
